// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame sequencer.
// Optional inter-byte timeout is enabled with UART_FRAME_TIMEOUT_EN.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8, synchronous write, asynchronous read.
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses SOF/CMD/LEN/payload/checksum frames and drains verified payloads.
// Define UART_FRAME_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle.
//
// state     | meaning
// S_IDLE    | hunting for SOF, other bytes ignored
// S_CMD     | waiting for command byte
// S_LEN     | waiting for length byte, range checked
// S_PAYLOAD | storing payload bytes into the buffer
// S_CSUM    | comparing received checksum to running XOR
// S_DRAIN   | streaming payload out; incoming bytes dropped as overrun
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic [7:0] out_cmd,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       overrun,
    output logic       busy
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int PW = AW + 1;

    state_t        state, state_d;
    logic [7:0]    cmd_q, cmd_d, csum_q, csum_d;
    logic [PW-1:0] len_q, len_d, wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
    logic          ok_d, err_d, ovr_d, valid_d;
    logic [1:0]    code_d;
    logic          buf_we;
    logic [7:0]    buf_rd;
    logic          xfer;
    logic          tmo_hit;

`ifdef UART_FRAME_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_cnt <= '0;
        else if (rx_ready || state == S_IDLE || state == S_DRAIN)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 32'd1;
    end

    // An arriving byte wins over an expiry on the same cycle.
    assign tmo_hit = !rx_ready && state != S_IDLE && state != S_DRAIN
                     && tmo_cnt == 32'(TIMEOUT_CYCLES - 1);
`else
    assign tmo_hit = 1'b0;
`endif

    uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (rx_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (buf_rd)
    );

    assign xfer     = out_valid & out_ready;
    assign out_last = out_valid && (rd_ptr == len_q - PW'(1));
    assign out_data = out_valid ? buf_rd : 8'h00;
    assign out_cmd  = cmd_q;
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_d  = state;
        cmd_d    = cmd_q;
        csum_d   = csum_q;
        len_d    = len_q;
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        ovr_d    = 1'b0;
        code_d   = err_code;
        valid_d  = out_valid;
        buf_we   = 1'b0;
        if (tmo_hit) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (rx_ready && rx_data == SOF_BYTE) begin
                    csum_d  = 8'h00;
                    state_d = S_CMD;
                end
                S_CMD: if (rx_ready) begin
                    cmd_d   = rx_data;
                    csum_d  = rx_data;
                    state_d = S_LEN;
                end
                S_LEN: if (rx_ready) begin
                    if (rx_data == 8'h00 || {1'b0, rx_data} > 9'(MAX_LEN)) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = S_IDLE;
                    end else begin
                        len_d    = PW'(rx_data);
                        csum_d   = csum_q ^ rx_data;
                        wr_ptr_d = '0;
                        state_d  = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: if (rx_ready) begin
                    buf_we   = 1'b1;
                    csum_d   = csum_q ^ rx_data;
                    wr_ptr_d = wr_ptr + PW'(1);
                    if (wr_ptr_d == len_q) state_d = S_CSUM;
                end
                S_CSUM: if (rx_ready) begin
                    if (rx_data == csum_q) begin
                        ok_d     = 1'b1;
                        valid_d  = 1'b1;
                        rd_ptr_d = '0;
                        state_d  = S_DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CSUM;
                        state_d = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (rx_ready) ovr_d = 1'b1;
                    if (xfer) begin
                        rd_ptr_d = rd_ptr + PW'(1);
                        if (out_last) begin
                            valid_d = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_q     <= '0;
            csum_q    <= '0;
            len_q     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            cmd_q     <= cmd_d;
            csum_q    <= csum_d;
            len_q     <= len_d;
            wr_ptr    <= wr_ptr_d;
            rd_ptr    <= rd_ptr_d;
            out_valid <= valid_d;
            frame_ok  <= ok_d;
            frame_err <= err_d;
            err_code  <= code_d;
            overrun   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl; timeout scenario runs when UART_FRAME_TIMEOUT_EN is defined.
module tb_uart_frame_ctrl;
    import uart_frame_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid, out_last, frame_ok, frame_err, overrun, busy;
    logic [7:0] out_data, out_cmd;
    logic [1:0] err_code;

    int pass_cnt = 0;
    int total_cnt = 0;
    int ok_cnt = 0, err_cnt = 0, ovr_cnt = 0;
    logic [7:0] cmd_seen;
    logic [8:0] rxq[$];

    always #5 clk = ~clk;

    uart_frame_ctrl #(.SOF_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_cmd(out_cmd), .frame_ok(frame_ok),
        .frame_err(frame_err), .err_code(err_code), .overrun(overrun), .busy(busy)
    );

    // Event monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (frame_ok) ok_cnt++;
        if (frame_err) err_cnt++;
        if (overrun) ovr_cnt++;
        if (out_valid && out_ready) begin
            rxq.push_back({out_last, out_data});
            cmd_seen = out_cmd;
        end
    end

    task automatic clear_counts();
        ok_cnt = 0; err_cnt = 0; ovr_cnt = 0;
        rxq.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #2;
        rx_data = b; rx_ready = 1'b1;
        @(posedge clk); #2;
        rx_ready = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        for (int i = 0; i < s.size(); i++) send_byte(s[i]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", name, busy, n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        total_cnt++;
        if ({out_valid, out_last, frame_ok, frame_err, overrun, busy, err_code, out_data, out_cmd} !== 24'h0)
            $display("FAIL reset_outputs: got %h want 000000",
                     {out_valid, out_last, frame_ok, frame_err, overrun, busy, err_code, out_data, out_cmd});
        else pass_cnt++;
        reset = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_good_frame();
        logic [7:0] s[$];
        clear_counts();
        out_ready = 1'b1;
        s = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        send_seq(s);
        total_cnt++;
        if ({frame_ok, out_valid, out_data} !== {1'b1, 1'b1, 8'h10})
            $display("FAIL good_latency: ok/valid/data=%b/%b/%h want 1/1/10", frame_ok, out_valid, out_data);
        else pass_cnt++;
        wait_idle("good");
        total_cnt++;
        if (rxq.size() != 2 || rxq[0] !== 9'h010 || rxq[1] !== 9'h120)
            $display("FAIL good_stream: size=%0d want 2 with {010,120}", rxq.size());
        else pass_cnt++;
        total_cnt++;
        if ({ok_cnt, err_cnt} != {32'd1, 32'd0} || cmd_seen !== 8'h01 || err_code !== 2'b00)
            $display("FAIL good_status: ok=%0d err=%0d cmd=%h code=%b want 1 0 01 00",
                     ok_cnt, err_cnt, cmd_seen, err_code);
        else pass_cnt++;
    endtask

    task automatic test_bad_csum();
        logic [7:0] s[$];
        clear_counts();
        out_ready = 1'b1;
        s = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
        send_seq(s);
        total_cnt++;
        if ({frame_err, err_code, out_valid, busy} !== {1'b1, ERR_CSUM, 1'b0, 1'b0})
            $display("FAIL csum_err: err/code/valid/busy=%b/%b/%b/%b want 1/10/0/0",
                     frame_err, err_code, out_valid, busy);
        else pass_cnt++;
        s = '{8'hA5, 8'h05, 8'h01, 8'hAA, 8'hAE};
        send_seq(s);
        wait_idle("csum_recover");
        total_cnt++;
        if (rxq.size() != 1 || rxq[0] !== 9'h1AA || cmd_seen !== 8'h05 || ok_cnt != 1 || err_cnt != 1)
            $display("FAIL csum_recover: size=%0d cmd=%h ok=%0d err=%0d want 1 05 1 1",
                     rxq.size(), cmd_seen, ok_cnt, err_cnt);
        else pass_cnt++;
    endtask

    task automatic test_bad_len();
        logic [7:0] s[$];
        clear_counts();
        s = '{8'hA5, 8'h07, 8'h00};
        send_seq(s);
        total_cnt++;
        if ({frame_err, err_code, busy} !== {1'b1, ERR_LEN, 1'b0})
            $display("FAIL len_zero: err/code/busy=%b/%b/%b want 1/01/0", frame_err, err_code, busy);
        else pass_cnt++;
        s = '{8'hA5, 8'h07, 8'h11};
        send_seq(s);
        total_cnt++;
        if ({frame_err, err_code, busy} !== {1'b1, ERR_LEN, 1'b0})
            $display("FAIL len_big: err/code/busy=%b/%b/%b want 1/01/0", frame_err, err_code, busy);
        else pass_cnt++;
        @(posedge clk); #2;
        total_cnt++;
        if (err_cnt != 2 || frame_err !== 1'b0 || err_code !== ERR_LEN)
            $display("FAIL len_count: errs=%0d pulse=%b code=%b want 2 0 01", err_cnt, frame_err, err_code);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [7:0] s[$];
        logic stable = 1'b1;
        clear_counts();
        out_ready = 1'b0;
        s = '{8'hA5, 8'h03, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        send_seq(s);
        total_cnt++;
        if ({frame_ok, out_valid, out_data, out_last} !== {1'b1, 1'b1, 8'h11, 1'b0})
            $display("FAIL bp_first: ok/valid/data/last=%b/%b/%h/%b want 1/1/11/0",
                     frame_ok, out_valid, out_data, out_last);
        else pass_cnt++;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #2;
            rx_data = 8'hA5;
            rx_ready = (c == 5 || c == 20 || c == 35);
            if (out_data !== 8'h11 || out_valid !== 1'b1 || out_last !== 1'b0 || out_cmd !== 8'h03)
                stable = 1'b0;
        end
        rx_ready = 1'b0;
        total_cnt++;
        if (ovr_cnt != 3 || !stable || busy !== 1'b1 || rxq.size() != 0)
            $display("FAIL bp_hold: overruns=%0d stable=%b busy=%b xfers=%0d want 3 1 1 0",
                     ovr_cnt, stable, busy, rxq.size());
        else pass_cnt++;
        out_ready = 1'b1;
        wait_idle("bp");
        total_cnt++;
        if (rxq.size() != 3 || rxq[0] !== 9'h011 || rxq[1] !== 9'h022 || rxq[2] !== 9'h133 || cmd_seen !== 8'h03)
            $display("FAIL bp_stream: size=%0d cmd=%h want 3 {011,022,133} 03", rxq.size(), cmd_seen);
        else pass_cnt++;
    endtask

    task automatic test_junk_boundary();
        logic [7:0] s[$];
        logic good = 1'b1;
        clear_counts();
        out_ready = 1'b1;
        s = '{8'h00, 8'hFF};
        send_seq(s);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL junk_ignored: busy=%b want 0", busy);
        else pass_cnt++;
        s = '{8'hA5, 8'h02, 8'h10};
        for (int i = 0; i < 16; i++) s.push_back(8'(i));
        s.push_back(8'h12);
        send_seq(s);
        wait_idle("junk");
        if (rxq.size() != 16) good = 1'b0;
        else for (int i = 0; i < 16; i++)
            if (rxq[i] !== {(i == 15), 8'(i)}) good = 1'b0;
        total_cnt++;
        if (!good || ok_cnt != 1 || err_cnt != 0)
            $display("FAIL max_len_stream: size=%0d ok=%0d err=%0d want 16 bytes 00..0F, 1, 0",
                     rxq.size(), ok_cnt, err_cnt);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        logic [7:0] s[$];
        clear_counts();
        out_ready = 1'b0;
        s = '{8'hA5, 8'h09, 8'h01, 8'h5A, 8'h52};
        send_seq(s);
        @(posedge clk); #2;
        out_ready = 1'b1; rx_data = 8'hA5; rx_ready = 1'b1;
        @(posedge clk); #2;
        rx_ready = 1'b0;
        total_cnt++;
        if ({overrun, out_valid, busy} !== 3'b100 || rxq.size() != 1 || rxq[0] !== 9'h15A)
            $display("FAIL simul_last: ovr/valid/busy=%b%b%b size=%0d want 100 1",
                     overrun, out_valid, busy, rxq.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] s[$];
        clear_counts();
        s = '{8'hA5, 8'h01, 8'h04, 8'h01, 8'h02};
        send_seq(s);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL mid_busy: busy=%b want 1", busy);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({out_valid, out_last, frame_ok, frame_err, overrun, busy, err_code, out_data, out_cmd} !== 24'h0)
            $display("FAIL mid_reset: got %h want 000000",
                     {out_valid, out_last, frame_ok, frame_err, overrun, busy, err_code, out_data, out_cmd});
        else pass_cnt++;
        @(posedge clk); #2;
        reset = 1'b0;
        s = '{8'h03, 8'h04, 8'h04};
        send_seq(s);
        repeat (3) @(posedge clk);
        #2;
        total_cnt++;
        if (busy !== 1'b0 || ok_cnt != 0 || out_valid !== 1'b0)
            $display("FAIL mid_discard: busy=%b ok=%0d valid=%b want 0 0 0", busy, ok_cnt, out_valid);
        else pass_cnt++;
    endtask

`ifdef UART_FRAME_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] s[$];
        int n = 0;
        clear_counts();
        s = '{8'hA5, 8'h01};
        send_seq(s);
        while (!frame_err && n < 150) begin
            @(posedge clk); #2;
            n++;
        end
        total_cnt++;
        if (n != 100 || err_code !== ERR_TIMEOUT || busy !== 1'b0)
            $display("FAIL timeout: cycles=%0d code=%b busy=%b want 100 11 0", n, err_code, busy);
        else pass_cnt++;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_len();
        test_backpressure();
        test_junk_boundary();
        test_simultaneous();
`ifdef UART_FRAME_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
- Sequencer behind the UART receiver.
- Consumes the byte stream (`rx_data` qualified by the single-cycle `rx_ready` pulse) and parses framed commands: SOF, CMD, LEN, payload, checksum.
- Buffers the payload and releases it to the downstream consumer (DDR/video config logic) over a valid/ready byte stream, only after the checksum verifies.
- Reports frame success and errors as single-cycle pulses.

Parameters:
- SOF_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 16, maximum payload bytes per frame (power of 2, 2..256).
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte from UART receiver.
- rx_ready  in  1  one-cycle strobe, rx_data valid.
- out_valid  out  1  payload byte available.
- out_ready  in  1  consumer accepts byte.
- out_data  out  8  payload byte.
- out_last  out  1  marks final payload byte of frame.
- out_cmd  out  8  CMD of frame being drained, stable during drain.
- frame_ok  out  1  one-cycle pulse, frame verified.
- frame_err  out  1  one-cycle pulse, frame discarded.
- err_code  out  2  cause, valid with frame_err: 01 bad LEN, 10 bad checksum, 11 timeout.
- overrun  out  1  one-cycle pulse, byte dropped while draining.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state): all outputs 0, state IDLE, buffer pointers 0, checksum 0. Reset mid-frame or mid-drain discards everything.
- Bytes are consumed only on cycles with `rx_ready`=1. The FSM advances on the clk edge where `rx_ready` is high.
- IDLE:
  - rx byte == SOF_BYTE -> CMD, clear checksum.
  - any other byte is ignored silently.
- CMD: latch cmd, checksum = byte -> LEN.
- LEN:
  - LEN==0 or LEN>MAX_LEN -> frame_err, err_code=01 next cycle, -> IDLE.
  - otherwise latch LEN, checksum ^= byte, wr_ptr=0 -> PAYLOAD.
- PAYLOAD:
  - write byte to buf[wr_ptr], checksum ^= byte, wr_ptr++.
  - when wr_ptr reaches LEN -> CSUM.
- CSUM:
  - byte == checksum -> frame_ok pulse, out_valid=1 on the following cycle, rd_ptr=0 -> DRAIN.
  - mismatch -> frame_err, err_code=10, -> IDLE.
- DRAIN:
  - out_data = buf[rd_ptr]; out_last = (rd_ptr==LEN-1).
  - Transfer occurs when out_valid & out_ready. rd_ptr++ on each transfer.
  - Transfer with out_last -> out_valid=0 next cycle, -> IDLE.
  - out_valid, out_data, out_last, out_cmd hold stable while out_ready=0.
  - rx_ready during DRAIN: byte dropped, overrun pulse next cycle. SOF is not detected here.
- Latency: frame_ok and the first out_valid appear one cycle after the checksum byte's rx_ready edge.
- err_code holds its last value between errors; it is meaningful only with frame_err.
- Storage: buffer is a MAX_LEN×8 register/distributed RAM array.
- Arithmetic: checksum is 8-bit XOR over CMD, LEN and all payload bytes. Pointers are $clog2(MAX_LEN)+1 bits wide, so LEN==MAX_LEN needs no wrap.
- Simultaneous events: rx_ready on the same cycle as the last drain transfer is dropped with overrun (state is still DRAIN that cycle).

Optional Feature:
- Macro: UART_FRAME_TIMEOUT_EN.
- Defined:
  - counter clears on every rx_ready and in IDLE/DRAIN, increments otherwise.
  - in CMD/LEN/PAYLOAD/CSUM, count == TIMEOUT_CYCLES-1 -> frame_err, err_code=11, -> IDLE.
  - if rx_ready arrives on the expiry cycle, the byte takes priority and the timeout is cancelled.
- Undefined: no counter is instantiated, a partial frame waits indefinitely, and err_code 11 never occurs.

Decomposition:
- Package uart_frame_pkg holds:
  - state encoding (IDLE, CMD, LEN, PAYLOAD, CSUM, DRAIN);
  - err_code constants ERR_LEN=2'b01, ERR_CSUM=2'b10, ERR_TIMEOUT=2'b11;
  - default SOF constant.
- Sub-module uart_frame_buf: a simple dual-port MAX_LEN×8 buffer (sync write, async read), instantiated once.

Test Plan:
- Good frame: bytes A5 01 02 10 20 33 -> frame_ok; stream 10 then 20 with out_last on 20; out_cmd=01; err_code unchanged.
- Bad checksum: A5 01 02 10 20 34 -> frame_err with err_code=10, no out_valid. A following valid frame is then accepted normally.
- Bad LEN: A5 07 00, then A5 07 11 (MAX_LEN=16) -> two frame_err with err_code=01, busy back to 0 after each.
- Backpressure/overrun: good frame with out_ready=0 for 50 cycles while 3 bytes arrive -> 3 overrun pulses, out_data stable, full payload delivered once out_ready=1.
- Junk/boundary: bytes 00 FF A5 02 10 (16 payload bytes 00..0F) plus correct checksum -> junk ignored, 16 bytes delivered, last flagged on 0F.
- Timeout (macro defined, TIMEOUT_CYCLES=100): A5 01, then silence -> frame_err with err_code=11 100 cycles after the last rx_ready. Also assert reset mid-PAYLOAD -> all outputs 0, FSM in IDLE.
